// File: rtl/pwm_step4096_core_if.sv
// Configuration/status bundle between an AXI4-Lite register file and the PWM core.
//
// Ports (signals):
//   cfg_enable    run request level
//   cfg_prescale  prescale register value (tick every prescale+1 clocks)
//   cfg_duty      duty register value (active ticks per period)
//   cfg_update    single-clock write strobe for prescale/duty
//   pwm_out       registered PWM output
//   period_tick   single-clock pulse after each counter wrap
//   update_ack    single-clock pulse when a pending set is applied
//   cnt_value     current step counter
//   busy          core is in RUN or DRAIN
//   fsm_state     debug view of the core state (0 IDLE, 1 RUN, 2 DRAIN)
//
// Handshake: there is no ready. cfg_update is a one-clock strobe that the core
// always accepts on the edge where it is high; cfg_duty/cfg_prescale only need
// to be valid on that edge. Status pulses are one clock wide and never stall.
interface pwm_step4096_core_if #(
    parameter int CNT_W      = 12,
    parameter int PRESCALE_W = 16
);
    logic                  cfg_enable;
    logic [PRESCALE_W-1:0] cfg_prescale;
    logic [CNT_W-1:0]      cfg_duty;
    logic                  cfg_update;
    logic                  pwm_out;
    logic                  period_tick;
    logic                  update_ack;
    logic [CNT_W-1:0]      cnt_value;
    logic                  busy;
    logic [1:0]            fsm_state;

    modport master (
        output cfg_enable, cfg_prescale, cfg_duty, cfg_update,
        input  pwm_out, period_tick, update_ack, cnt_value, busy, fsm_state
    );

    modport slave (
        input  cfg_enable, cfg_prescale, cfg_duty, cfg_update,
        output pwm_out, period_tick, update_ack, cnt_value, busy, fsm_state
    );
endinterface

// File: rtl/pwm_step4096_core.sv
// PWM generator core with a 2**CNT_W-step period.
// Duty/prescale writes are held in a pending set and only reach the active
// shadow registers at a period wrap, so the waveform never glitches. Dropping
// enable lets the current period finish (DRAIN) before the output parks.
//
// Ports:
//   clock   system clock
//   reset   synchronous, active-high
//   bus     slave side of pwm_step4096_core_if (cfg inputs, status outputs)
module pwm_step4096_core #(
    parameter int CNT_W      = 12,
    parameter int PRESCALE_W = 16,
    parameter bit INVERT     = 1'b0
) (
    input logic                  clock,
    input logic                  reset,
    pwm_step4096_core_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0]      CNT_MAX = '1;
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

    state_t                state, state_next;
    logic [PRESCALE_W-1:0] pre_cnt, pre_cnt_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [CNT_W-1:0]      duty_sh, duty_sh_next;
    logic [PRESCALE_W-1:0] pre_sh, pre_sh_next;
    logic [CNT_W-1:0]      pend_duty, pend_duty_next;
    logic [PRESCALE_W-1:0] pend_pre, pend_pre_next;
    logic                  pend_flag, pend_flag_next;
    logic                  pwm_q, pwm_next;
    logic                  period_tick_q, update_ack_q;
    logic                  tick, wrap, apply, busy_next;

    // A tick only exists while the counter runs; IDLE holds everything at 0.
    // An update strobe on the wrap edge counts as pending for that wrap.
    always_comb begin
        tick  = (state != ST_IDLE) && (pre_cnt == pre_sh);
        wrap  = tick && (cnt == CNT_MAX);
        apply = wrap && (pend_flag || bus.cfg_update);
    end

    always_comb begin
        state_next     = state;
        pre_cnt_next   = pre_cnt;
        cnt_next       = cnt;
        duty_sh_next   = duty_sh;
        pre_sh_next    = pre_sh;
        pend_duty_next = pend_duty;
        pend_pre_next  = pend_pre;
        pend_flag_next = pend_flag;

        // Last write wins: a later strobe simply overwrites the pending set.
        if (bus.cfg_update) begin
            pend_duty_next = bus.cfg_duty;
            pend_pre_next  = bus.cfg_prescale;
            pend_flag_next = 1'b1;
        end

        unique case (state)
            ST_IDLE: begin
                pre_cnt_next = '0;
                cnt_next     = '0;
                // Enabling loads the shadows straight from the registers and
                // discards whatever was pending while idle.
                if (bus.cfg_enable) begin
                    state_next     = ST_RUN;
                    duty_sh_next   = bus.cfg_duty;
                    pre_sh_next    = bus.cfg_prescale;
                    pend_flag_next = 1'b0;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (tick) begin
                    pre_cnt_next = '0;
                    cnt_next     = cnt + CNT_ONE;   // modular: MAX wraps to 0
                end else begin
                    pre_cnt_next = pre_cnt + PRE_ONE;
                end
                if (apply) begin
                    duty_sh_next   = bus.cfg_update ? bus.cfg_duty     : pend_duty;
                    pre_sh_next    = bus.cfg_update ? bus.cfg_prescale : pend_pre;
                    pend_flag_next = 1'b0;
                end
                if (bus.cfg_enable) begin
                    state_next = ST_RUN;
                end else if ((state == ST_DRAIN) && wrap) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_DRAIN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Output is computed from next-cycle values so pwm_out lines up with
        // cnt_value in the same cycle.
        busy_next = (state_next != ST_IDLE);
        pwm_next  = (busy_next && (cnt_next < duty_sh_next)) ^ INVERT;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            pre_cnt       <= '0;
            cnt           <= '0;
            duty_sh       <= '0;
            pre_sh        <= '0;
            pend_duty     <= '0;
            pend_pre      <= '0;
            pend_flag     <= 1'b0;
            pwm_q         <= INVERT;
            period_tick_q <= 1'b0;
            update_ack_q  <= 1'b0;
        end else begin
            state         <= state_next;
            pre_cnt       <= pre_cnt_next;
            cnt           <= cnt_next;
            duty_sh       <= duty_sh_next;
            pre_sh        <= pre_sh_next;
            pend_duty     <= pend_duty_next;
            pend_pre      <= pend_pre_next;
            pend_flag     <= pend_flag_next;
            pwm_q         <= pwm_next;
            period_tick_q <= wrap;
            update_ack_q  <= apply;
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.period_tick = period_tick_q;
    assign bus.update_ack  = update_ack_q;
    assign bus.cnt_value   = cnt;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_pwm_step4096_core.sv
module tb_pwm_step4096_core;
    localparam int CNT_W      = 12;
    localparam int PRESCALE_W = 16;
    localparam int MAXC       = 4096;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   chk_en   = 0;

    pwm_step4096_core_if #(.CNT_W(CNT_W), .PRESCALE_W(PRESCALE_W)) bus ();

    pwm_step4096_core #(.CNT_W(CNT_W), .PRESCALE_W(PRESCALE_W), .INVERT(1'b0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Behavioural view: an active flag, a sub-tick clock count, a step number
    // modulo 4096, the active and pending settings, and whether enable was
    // seen low on the previous edge while active.
    typedef struct {
        bit active;
        bit enable_was_low;
        int sub;
        int step;
        int duty;
        int presc;
        bit pv;
        int p_duty;
        int p_presc;
        bit pwm;
        bit tick;
        bit ack;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t cur, bit rst, bit en, bit upd, int duty, int presc);
        model_t n;
        bit     wrapped;
        n       = cur;
        wrapped = 0;
        n.tick  = 0;
        n.ack   = 0;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        if (upd) begin
            n.pv      = 1;
            n.p_duty  = duty;
            n.p_presc = presc;
        end
        if (!cur.active) begin
            if (en) begin
                n.active         = 1;
                n.enable_was_low = 0;
                n.duty           = duty;
                n.presc          = presc;
                n.pv             = 0;
            end
        end else begin
            if (cur.sub < cur.presc) begin
                n.sub = cur.sub + 1;
            end else begin
                n.sub   = 0;
                wrapped = (cur.step == MAXC - 1);
                n.step  = (cur.step + 1) % MAXC;
            end
            if (wrapped) begin
                n.tick = 1;
                if (cur.pv || upd) begin
                    n.ack   = 1;
                    n.pv    = 0;
                    n.duty  = upd ? duty  : cur.p_duty;
                    n.presc = upd ? presc : cur.p_presc;
                end
                if (cur.enable_was_low && !en) n.active = 0;
            end
            n.enable_was_low = !en;
        end
        n.pwm = n.active && (n.step < n.duty);
        return n;
    endfunction

    always @(posedge clock)
        m <= model_next(m, reset, bus.cfg_enable, bus.cfg_update,
                        int'(bus.cfg_duty), int'(bus.cfg_prescale));

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Every cycle: {pwm, tick, ack, busy, cnt} against the model.
    always @(negedge clock)
        if (chk_en)
            check("model", {bus.pwm_out, bus.period_tick, bus.update_ack, bus.busy, bus.cnt_value},
                  {m.pwm, m.tick, m.ack, m.active, 12'(m.step)});

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.cfg_enable = 1'b0;
        bus.cfg_update = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic start(input int duty, input int presc);
        bus.cfg_duty     = 12'(duty);
        bus.cfg_prescale = 16'(presc);
        bus.cfg_enable   = 1'b1;
    endtask

    task automatic pulse_update(input int duty, input int presc);
        bus.cfg_duty     = 12'(duty);
        bus.cfg_prescale = 16'(presc);
        bus.cfg_update   = 1'b1;
        @(negedge clock);
        bus.cfg_update   = 1'b0;
    endtask

    task automatic wait_cnt(input int v, input string name);
        int k;
        k = 0;
        while ((int'(bus.cnt_value) != v) && (k < 40000)) begin
            @(negedge clock);
            k++;
        end
        if (k >= 40000) timeout(name);
    endtask

    task automatic wait_tick(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!bus.period_tick && (k < 40000));
        if (k >= 40000) timeout(name);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        int presc;
        int duty;
        int exp_high;
        int exp_period;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int   n_clk;
        int   n_high;
        int   prev;
        int   breaks;

        vecs[0] = '{presc: 0, duty: 2048, exp_high: 2048, exp_period: 4096};
        vecs[1] = '{presc: 1, duty: 1024, exp_high: 2048, exp_period: 8192};
        vecs[2] = '{presc: 0, duty: 0,    exp_high: 0,    exp_period: 4096};
        vecs[3] = '{presc: 0, duty: 4095, exp_high: 4095, exp_period: 4096};
        vecs[4] = '{presc: 0, duty: 1,    exp_high: 1,    exp_period: 4096};

        reset            = 1'b1;
        bus.cfg_enable   = 1'b0;
        bus.cfg_update   = 1'b0;
        bus.cfg_duty     = '0;
        bus.cfg_prescale = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_en = 1;

        check("reset_outputs", {bus.pwm_out, bus.period_tick, bus.update_ack, bus.busy, bus.cnt_value}, 32'h0);

        // Table: one full period from enable, measuring length and high time.
        for (int i = 0; i < 5; i++) begin
            apply_reset();
            start(vecs[i].duty, vecs[i].presc);
            n_clk  = 0;
            n_high = 0;
            forever begin
                @(negedge clock);
                if (bus.period_tick || (n_clk > 20000)) break;
                n_clk++;
                n_high += int'(bus.pwm_out);
            end
            check($sformatf("vec%0d_period", i), n_clk, vecs[i].exp_period);
            check($sformatf("vec%0d_high", i), n_high, vecs[i].exp_high);
            check($sformatf("vec%0d_cnt_at_tick", i), bus.cnt_value, 32'h0);
        end

        // Update mid-period takes effect at the next wrap only.
        apply_reset();
        start(1000, 0);
        wait_cnt(500, "upd_500");
        pulse_update(3000, 0);
        wait_cnt(1500, "upd_1500");
        check("old_duty_kept", bus.pwm_out, 32'h0);
        wait_tick("upd_tick");
        check("ack_with_tick", bus.update_ack, 32'h1);
        wait_cnt(2000, "upd_2000");
        check("new_duty_used", bus.pwm_out, 32'h1);

        // Two updates in one period: the last one wins.
        apply_reset();
        start(1000, 0);
        wait_cnt(100, "two_100");
        pulse_update(3000, 0);
        wait_cnt(200, "two_200");
        pulse_update(100, 0);
        wait_tick("two_tick");
        check("two_ack", bus.update_ack, 32'h1);
        wait_cnt(50, "two_50");
        check("two_low_duty_on", bus.pwm_out, 32'h1);
        wait_cnt(150, "two_150");
        check("two_last_wins", bus.pwm_out, 32'h0);

        // Update strobe on the wrap edge applies at that wrap.
        apply_reset();
        start(1000, 0);
        wait_cnt(4095, "edge_4095");
        pulse_update(200, 0);
        check("edge_tick_ack", {bus.period_tick, bus.update_ack}, 32'h3);
        wait_cnt(500, "edge_500");
        check("edge_new_duty", bus.pwm_out, 32'h0);

        // Disable finishes the period, then parks.
        apply_reset();
        start(2048, 0);
        wait_cnt(10, "drain_10");
        bus.cfg_enable = 1'b0;
        wait_cnt(4000, "drain_4000");
        check("drain_busy", bus.busy, 32'h1);
        wait_tick("drain_tick");
        check("drain_parked", {bus.busy, bus.pwm_out, bus.cnt_value}, 32'h0);
        repeat (5) @(negedge clock);
        check("drain_stays_idle", {bus.busy, bus.cnt_value}, 32'h0);

        // Re-enable during DRAIN: counter continuous, no idle visit.
        apply_reset();
        start(2048, 0);
        wait_cnt(10, "re_10");
        bus.cfg_enable = 1'b0;
        wait_cnt(15, "re_15");
        breaks = 0;
        prev   = int'(bus.cnt_value);
        for (int k = 0; k < 30; k++) begin
            if (k == 5) bus.cfg_enable = 1'b1;
            @(negedge clock);
            if ((int'(bus.cnt_value) != prev + 1) || !bus.busy) breaks++;
            prev = int'(bus.cnt_value);
        end
        check("reenable_continuous", breaks, 32'h0);
        wait_tick("re_tick");
        check("reenable_still_busy", bus.busy, 32'h1);

        // Reset mid-run with a pending update; re-enable uses direct load.
        apply_reset();
        start(1000, 0);
        wait_cnt(1500, "rst_1500");
        pulse_update(3000, 0);
        wait_cnt(2000, "rst_2000");
        reset = 1'b1;
        bus.cfg_duty = 12'd500;
        @(negedge clock);
        check("midrun_reset_outputs", {bus.pwm_out, bus.period_tick, bus.update_ack, bus.busy, bus.cnt_value}, 32'h0);
        reset = 1'b0;
        wait_cnt(700, "rst_700");
        check("direct_load_after_reset", bus.pwm_out, 32'h0);

        // Randomized run against the model.
        apply_reset();
        start($urandom_range(0, 4095), $urandom_range(0, 1));
        for (int k = 0; k < 14000; k++) begin
            @(negedge clock);
            bus.cfg_duty     = 12'($urandom_range(0, 4095));
            bus.cfg_prescale = 16'($urandom_range(0, 1));
            bus.cfg_update   = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 2999) == 0) bus.cfg_enable = ~bus.cfg_enable;
        end
        bus.cfg_update = 1'b0;
        @(negedge clock);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
